// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: load/store opcodes, access sizes, FSM states.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_access_stage_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
    typedef enum logic       {IDLE, BUSY}       state_t;

    // Unknown opcodes carrying a memop fall back to a word access.
    function automatic size_t op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = SZ_B;
            OP_LH, OP_LHU, OP_SH: op_size = SZ_H;
            default:              op_size = SZ_W;
        endcase
    endfunction

    function automatic logic op_signed(input logic [5:0] op);
        op_signed = (op == OP_LB) || (op == OP_LH);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: byte enables, store replication, load extract/extend, alignment check.
// Latency: purely combinational.
// Backpressure: none; ports: size/addr_lo/rt/rdata/sign in -> be/wdata/ldata/misaligned out.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  size_t       i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rt,
    input  logic [31:0] i_rdata,
    input  logic        i_sign,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be         = 4'b1111;
        o_wdata      = i_rt;
        o_ldata      = i_rdata;
        o_misaligned = 1'b0;
        w_byte       = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half       = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
        case (i_size)
            SZ_B: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_rt[7:0]}};
                o_ldata = {{24{i_sign & w_byte[7]}}, w_byte};
            end
            SZ_H: begin
                o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_rt[15:0]}};
                o_ldata      = {{16{i_sign & w_half[15]}}, w_half};
                o_misaligned = i_addr_lo[0];
            end
            default: begin
                o_misaligned = |i_addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues dmem loads/stores over req/ack, registers the MEM/WB bundle.
// Latency: 1 cycle without memop; >= 2 cycles with memop (ack in first BUSY cycle).
// Backpressure: stall_out holds upstream while a request is outstanding; timeout aborts it.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALU_C_IN,
    input  logic [31:0] RT_DATA_IN,
    input  logic [4:0]  reg_rd_in,
    input  logic [31:0] INSTR_IN,
    input  logic        MEMR_IN,
    input  logic        MEMW_IN,
    input  logic        REGW_IN,
    input  logic        MEM2R_IN,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_out,
    output logic [31:0] ALU_C_OUT,
    output logic [31:0] MEM_DATA_OUT,
    output logic [31:0] INSTR_OUT,
    output logic [4:0]  reg_rd_out,
    output logic        REGW_OUT,
    output logic        MEM2R_OUT,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_memop;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata, w_ldata;
    logic               w_misal;
    logic               w_timeout;

    // MEM/WB load controls
    logic               w_bubble;
    logic               w_wb_regw, w_wb_m2r;
    logic [31:0]        w_wb_data;

    assign w_memop = MEMR_IN | MEMW_IN;

    // EX/MEM is frozen by stall_out while BUSY, so the live inputs still describe the access.
    mem_lane_align u_lane (
        .i_size       (op_size(INSTR_IN[31:26])),
        .i_addr_lo    (ALU_C_IN[1:0]),
        .i_rt         (RT_DATA_IN),
        .i_rdata      (dmem_rdata),
        .i_sign       (op_signed(INSTR_IN[31:26])),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_ldata      (w_ldata),
        .o_misaligned (w_misal)
    );

    assign w_timeout = (TIMEOUT > 0) && (r_cnt == CNT_LAST);

    always_comb begin
        w_next       = r_state;
        stall_out    = 1'b0;
        misalign_err = 1'b0;
        bus_err      = 1'b0;
        w_bubble     = 1'b0;
        w_wb_regw    = REGW_IN;
        w_wb_m2r     = MEM2R_IN;
        w_wb_data    = '0;
        case (r_state)
            IDLE: begin
                if (w_memop && w_misal) begin
                    misalign_err = 1'b1;
                    w_wb_regw    = 1'b0;
                    w_wb_m2r     = 1'b0;
                end else if (w_memop) begin
                    stall_out = 1'b1;
                    w_bubble  = 1'b1;
                    w_next    = BUSY;
                end
            end
            BUSY: begin
                // ack takes priority over a coincident timeout
                if (dmem_ack) begin
                    w_wb_data = MEMW_IN ? 32'd0 : w_ldata;
                    w_next    = IDLE;
                end else if (w_timeout) begin
                    bus_err   = 1'b1;
                    w_wb_regw = 1'b0;
                    w_next    = IDLE;
                end else begin
                    stall_out = 1'b1;
                    w_bubble  = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            ALU_C_OUT    <= '0;
            MEM_DATA_OUT <= '0;
            INSTR_OUT    <= '0;
            reg_rd_out   <= '0;
            REGW_OUT     <= 1'b0;
            MEM2R_OUT    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == BUSY && w_next == BUSY) ? r_cnt + CNT_W'(1) : '0;

            if (r_state == IDLE && w_next == BUSY) begin
                dmem_req   <= 1'b1;
                dmem_we    <= MEMW_IN;
                dmem_addr  <= {ALU_C_IN[31:2], 2'b00};
                dmem_be    <= w_be;
                dmem_wdata <= w_wdata;
            end else if (r_state == BUSY && w_next == IDLE) begin
                dmem_req   <= 1'b0;
                dmem_we    <= 1'b0;
                dmem_addr  <= '0;
                dmem_be    <= '0;
                dmem_wdata <= '0;
            end

            if (w_bubble) begin
                ALU_C_OUT    <= '0;
                MEM_DATA_OUT <= '0;
                INSTR_OUT    <= '0;
                reg_rd_out   <= '0;
                REGW_OUT     <= 1'b0;
                MEM2R_OUT    <= 1'b0;
            end else begin
                ALU_C_OUT    <= ALU_C_IN;
                MEM_DATA_OUT <= w_wb_data;
                INSTR_OUT    <= INSTR_IN;
                reg_rd_out   <= reg_rd_in;
                REGW_OUT     <= w_wb_regw;
                MEM2R_OUT    <= w_wb_m2r;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALU_C_IN, RT_DATA_IN, INSTR_IN, dmem_rdata;
    logic [4:0]  reg_rd_in;
    logic        MEMR_IN, MEMW_IN, REGW_IN, MEM2R_IN, dmem_ack;
    logic        dmem_req, dmem_we, stall_out, misalign_err, bus_err, REGW_OUT, MEM2R_OUT;
    logic [31:0] dmem_addr, dmem_wdata, ALU_C_OUT, MEM_DATA_OUT, INSTR_OUT;
    logic [3:0]  dmem_be;
    logic [4:0]  reg_rd_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .ALU_C_IN(ALU_C_IN), .RT_DATA_IN(RT_DATA_IN), .reg_rd_in(reg_rd_in), .INSTR_IN(INSTR_IN),
        .MEMR_IN(MEMR_IN), .MEMW_IN(MEMW_IN), .REGW_IN(REGW_IN), .MEM2R_IN(MEM2R_IN),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall_out(stall_out),
        .ALU_C_OUT(ALU_C_OUT), .MEM_DATA_OUT(MEM_DATA_OUT), .INSTR_OUT(INSTR_OUT),
        .reg_rd_out(reg_rd_out), .REGW_OUT(REGW_OUT), .MEM2R_OUT(MEM2R_OUT),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_nop();
        ALU_C_IN = '0; RT_DATA_IN = '0; INSTR_IN = '0; reg_rd_in = '0;
        MEMR_IN = 0; MEMW_IN = 0; REGW_IN = 0; MEM2R_IN = 0;
        dmem_ack = 0; dmem_rdata = '0;
    endtask

    // Reference: access width in bytes and signedness straight from the opcode table.
    function automatic int nbytes(input logic [5:0] op);
        case (op)
            6'h20, 6'h24, 6'h28: return 1;
            6'h21, 6'h25, 6'h29: return 2;
            default:             return 4;
        endcase
    endfunction

    // Starts just after a posedge, ends at the negedge where the resulting MEM/WB is visible.
    // delay = BUSY cycles without ack before the ack cycle; negative = never ack.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] rt, input logic [31:0] rdata,
                          input logic mr, input logic mw, input logic rw, input logic m2r,
                          input int delay, output int stalls);
        int          n, off;
        logic        sgn, mis;
        logic [31:0] instr, mask, exp_wd, exp_ld, be_full;
        logic [4:0]  rd;
        bit          done;
        n      = nbytes(op);
        off    = int'(a % 4);
        sgn    = (op == 6'h20) || (op == 6'h21);
        mis    = (a % n) != 0;
        mask   = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
        be_full = ((32'd1 << n) - 1) << off;
        exp_wd = (n == 1) ? rt[7:0] * 32'h0101_0101 : (n == 2) ? rt[15:0] * 32'h0001_0001 : rt;
        exp_ld = (rdata >> (8 * off)) & mask;
        if (sgn && exp_ld[8 * n - 1]) exp_ld = exp_ld | ~mask;
        if (mw) exp_ld = 0;
        instr  = {op, 26'($urandom)};
        rd     = 5'($urandom);
        stalls = 0;

        @(posedge clk); #1;
        ALU_C_IN = a; RT_DATA_IN = rt; INSTR_IN = instr; reg_rd_in = rd;
        MEMR_IN = mr; MEMW_IN = mw; REGW_IN = rw; MEM2R_IN = m2r;
        @(negedge clk);
        if (stall_out) stalls++;
        chk({tag, ".idle_req"}, dmem_req, 0);
        if (!(mr | mw)) begin
            chk({tag, ".nop_stall"}, stall_out, 0);
            @(posedge clk); #1; set_nop();
            @(negedge clk);
            chk({tag, ".regw"}, REGW_OUT, rw);
            chk({tag, ".m2r"}, MEM2R_OUT, m2r);
            chk({tag, ".data"}, MEM_DATA_OUT, 0);
        end else if (mis) begin
            chk({tag, ".mis_stall"}, stall_out, 0);
            chk({tag, ".mis_err"}, misalign_err, 1);
            @(posedge clk); #1; set_nop();
            @(negedge clk);
            chk({tag, ".mis_req"}, dmem_req, 0);
            chk({tag, ".mis_regw"}, REGW_OUT, 0);
            chk({tag, ".mis_m2r"}, MEM2R_OUT, 0);
        end else begin
            chk({tag, ".mis_err0"}, misalign_err, 0);
            done = 0;
            for (int k = 0; k < TO + 4 && !done; k++) begin
                @(posedge clk); #1;
                if (k == delay) begin dmem_ack = 1; dmem_rdata = rdata; end
                else dmem_rdata = 32'($urandom);
                @(negedge clk);
                if (k == 0) begin
                    chk({tag, ".req"}, dmem_req, 1);
                    chk({tag, ".we"}, dmem_we, mw);
                    chk({tag, ".addr"}, dmem_addr, a & 32'hFFFF_FFFC);
                    chk({tag, ".be"}, dmem_be, be_full[3:0]);
                    chk({tag, ".wdata"}, dmem_wdata, exp_wd);
                    chk({tag, ".bubble"}, {REGW_OUT, ALU_C_OUT}, 0);
                end
                if (stall_out) stalls++;
                if (k == delay) begin
                    chk({tag, ".ack_stall"}, stall_out, 0);
                    chk({tag, ".ack_buserr"}, bus_err, 0);
                    @(posedge clk); #1; set_nop();
                    @(negedge clk);
                    chk({tag, ".ld"}, MEM_DATA_OUT, exp_ld);
                    chk({tag, ".regw"}, REGW_OUT, rw);
                    chk({tag, ".alu"}, ALU_C_OUT, a);
                    chk({tag, ".instr"}, INSTR_OUT, instr);
                    chk({tag, ".rd"}, reg_rd_out, rd);
                    chk({tag, ".req_drop"}, dmem_req, 0);
                    done = 1;
                end else if (k == TO - 1) begin
                    chk({tag, ".to_stall"}, stall_out, 0);
                    chk({tag, ".bus_err"}, bus_err, 1);
                    @(posedge clk); #1; set_nop();
                    @(negedge clk);
                    chk({tag, ".to_regw"}, REGW_OUT, 0);
                    chk({tag, ".to_req"}, dmem_req, 0);
                    done = 1;
                end else begin
                    chk({tag, ".busy_stall"}, stall_out, 1);
                end
            end
            chk({tag, ".completed"}, done, 1);
        end
    endtask

    initial begin
        int st;
        logic [5:0] ops [9];
        logic [5:0] op;
        int sel;
        ops = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h28, 6'h29, 6'h2B, 6'h0F};
        set_nop();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.req", dmem_req, 0);
        chk("rst.stall", stall_out, 0);
        chk("rst.errs", {misalign_err, bus_err}, 0);
        chk("rst.wb", {REGW_OUT, MEM2R_OUT, ALU_C_OUT, MEM_DATA_OUT}, 0);
        #1 rst = 0;

        // lw, ack after three BUSY cycles
        run_op("lw", 6'h23, 32'h100, 0, 32'hDEADBEEF, 1, 0, 1, 1, 3, st);
        chk("lw.stalls", st, 4);
        chk("lw.val", MEM_DATA_OUT, 32'hDEADBEEF);
        chk("lw.regw1", REGW_OUT, 1);

        run_op("lb", 6'h20, 32'h103, 0, 32'h80FF_0000, 1, 0, 1, 1, 0, st);
        chk("lb.val", MEM_DATA_OUT, 32'hFFFF_FF80);
        run_op("lbu", 6'h24, 32'h103, 0, 32'h80FF_0000, 1, 0, 1, 1, 1, st);
        chk("lbu.val", MEM_DATA_OUT, 32'h0000_0080);

        run_op("sh", 6'h29, 32'h202, 32'h1234ABCD, 0, 0, 1, 0, 0, 0, st);
        chk("sh.stalls", st, 1);

        run_op("lw_mis", 6'h23, 32'h101, 0, 0, 1, 0, 1, 1, 0, st);
        chk("lw_mis.stalls", st, 0);

        run_op("timeout", 6'h23, 32'h300, 0, 0, 1, 0, 1, 1, -1, st);
        chk("timeout.stalls", st, TO);

        // reset while BUSY, then a stray ack
        @(posedge clk); #1;
        ALU_C_IN = 32'h400; INSTR_IN = {6'h23, 26'd0}; MEMR_IN = 1; REGW_IN = 1; MEM2R_IN = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstbusy.req1", dmem_req, 1);
        @(posedge clk); #1; rst = 1; set_nop();
        @(posedge clk); #1; rst = 0; dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("rstbusy.req0", dmem_req, 0);
        chk("rstbusy.errs", {stall_out, misalign_err, bus_err}, 0);
        @(posedge clk); #1; dmem_ack = 0;
        @(negedge clk);
        chk("rstbusy.wb", {REGW_OUT, MEM2R_OUT, MEM_DATA_OUT, ALU_C_OUT}, 0);
        chk("rstbusy.req", dmem_req, 0);

        for (int i = 0; i < 40; i++) begin
            op  = ops[$urandom_range(0, 8)];
            sel = $urandom_range(0, 3);
            run_op($sformatf("rnd%0d", i), op, $urandom, $urandom, $urandom,
                   sel[0], sel[1], 1'($urandom), 1'($urandom), $urandom_range(0, 4), st);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
